// File: rtl/mul_div_unit.sv
// RV32M multiply/divide unit: 32-step shift-add / restoring divide,
// fixed 33-cycle latency with a one-cycle done pulse.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] opd_q;
  logic [2:0]  op_q;
  logic [4:0]  rdc_q;
  logic        negq_q;
  logic        negr_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] result_q;
  logic [4:0]  rd_q;

  logic        a_sgn;
  logic        b_sgn;
  logic        is_div;
  logic        b_zero;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  always_comb begin
    a_sgn  = rs1_val[31] & ((op == OP_MULH) | (op == OP_MULHSU) |
                            (op == OP_DIV)  | (op == OP_REM));
    b_sgn  = rs2_val[31] & ((op == OP_MULH) | (op == OP_DIV) |
                            (op == OP_REM));
    is_div = op[2];
    b_zero = (rs2_val == 32'd0);
    a_mag  = a_sgn ? (~rs1_val + 32'd1) : rs1_val;
    b_mag  = b_sgn ? (~rs2_val + 32'd1) : rs2_val;
  end

  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic [32:0] div_diff;
  logic [63:0] step_d;

  // acc holds {partial product, multiplier} or {remainder, quotient}
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} +
               {1'b0, (acc_q[0] ? opd_q : 32'd0)};
    div_sh   = acc_q[63:31];
    div_diff = div_sh - {1'b0, opd_q};
    if (op_q[2]) begin
      if (div_diff[32])
        step_d = {div_sh[31:0], acc_q[30:0], 1'b0};
      else
        step_d = {div_diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      step_d = {mul_sum, acc_q[31:1]};
    end
  end

  logic [63:0] prod_d;
  logic [31:0] quo_d;
  logic [31:0] rem_d;
  logic [31:0] result_d;

  always_comb begin
    prod_d = negq_q ? (~acc_q + 64'd1) : acc_q;
    quo_d  = negq_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_d  = negr_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    unique case (op_q)
      OP_MUL:    result_d = prod_d[31:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  result_d = prod_d[63:32];
      OP_DIV,
      OP_DIVU:   result_d = quo_d;
      default:   result_d = rem_d;
    endcase
  end

  // quotient sign is suppressed on divide-by-zero so it stays all ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      opd_q    <= 32'd0;
      op_q     <= 3'd0;
      rdc_q    <= 5'd0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
      rd_q     <= 5'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            acc_q   <= {32'd0, (is_div ? a_mag : b_mag)};
            opd_q   <= is_div ? b_mag : a_mag;
            op_q    <= op;
            rdc_q   <= rd_in;
            negq_q  <= (a_sgn ^ b_sgn) & ~(is_div & b_zero);
            negr_q  <= is_div & a_sgn;
            cnt_q   <= 6'd0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= step_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31)
            state_q <= FIX;
        end
        FIX: begin
          result_q <= result_d;
          rd_q     <= rdc_q;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          cnt_q    <= 6'd0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed literal cases plus random ops
// checked every cycle against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1_val = 32'd0;
  logic [31:0] rs2_val = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mul_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // reference: accepted at edge T0, completes at T33
  logic        m_busy, m_done;
  logic [31:0] m_res, p_res;
  logic [4:0]  m_rd, p_rd;
  int          m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0;
      m_res  <= 32'd0; m_rd  <= 5'd0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
          m_res  <= p_res; m_rd  <= p_rd;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_busy <= 1'b1;
        m_left <= 33;
        p_res  <= ref_op(op, rs1_val, rs2_val);
        p_rd   <= rd_in;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (chk_en) begin
        chk("cyc busy", busy, m_busy);
        chk("cyc done", done, m_done);
        chk("cyc result", result, m_res);
        chk("cyc rd_out", rd_out, m_rd);
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic scramble();
    op      = 3'($urandom_range(0, 7));
    rs1_val = $urandom;
    rs2_val = $urandom;
    rd_in   = 5'($urandom_range(0, 31));
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    op = o; rs1_val = a; rs2_val = b; rd_in = rd;
    start = 1'b1;
  endtask

  task automatic wait_done(input logic [31:0] exp, input logic [4:0] erd,
                           input string nm, input int ign_at);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin start = 1'b0; scramble(); end
      if (ign_at > 0 && n == ign_at) begin start = 1'b1; scramble(); end
      if (ign_at > 0 && n == ign_at + 1) start = 1'b0;
    end while (!done && n < 40);
    chk({nm, " latency"}, 64'(n - 1), 64'd33);
    chk({nm, " result"}, result, exp);
    chk({nm, " rd_out"}, rd_out, erd);
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd,
                     input logic [31:0] exp, input string nm);
    @(negedge clk);
    issue(o, a, b, rd);
    wait_done(exp, rd, nm, 0);
  endtask

  initial begin
    int dn;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset result", result, 32'd0);
    chk("reset rd_out", rd_out, 5'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    run(3'd0, 32'd7, 32'd6, 5'd5, 32'd42, "MUL 7x6");
    run(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h0, "MULH -1x-1");
    run(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, "MULHU");
    run(3'd2, 32'hFFFFFFFF, 32'd2, 5'd3, 32'hFFFFFFFF, "MULHSU");
    run(3'd4, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFD, "DIV -7/2");
    run(3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, "REM -7/2");
    run(3'd5, 32'd100, 32'd7, 5'd7, 32'd14, "DIVU 100/7");
    run(3'd7, 32'd100, 32'd7, 5'd8, 32'd2, "REMU 100/7");
    run(3'd4, 32'd5, 32'd0, 5'd9, 32'hFFFFFFFF, "DIV 5/0");
    run(3'd6, 32'd5, 32'd0, 5'd10, 32'd5, "REM 5/0");
    run(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, "DIV ovf");
    run(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0, "REM ovf");
    run(3'd4, 32'hFFFFFFFB, 32'd0, 5'd13, 32'hFFFFFFFF, "DIV -5/0");
    run(3'd6, 32'hFFFFFFFB, 32'd0, 5'd14, 32'hFFFFFFFB, "REM -5/0");

    @(negedge clk);
    issue(3'd0, 32'd12, 32'd11, 5'd15);
    wait_done(32'd132, 5'd15, "MUL ignore start", 10);
    issue(3'd5, 32'd1000, 32'd10, 5'd16);
    wait_done(32'd100, 5'd16, "DIVU back2back", 0);

    @(negedge clk);
    issue(3'd4, 32'd1000, 32'd7, 5'd17);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort result", result, 32'd0);
    chk("abort rd_out", rd_out, 5'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("abort no done", 64'(dn), 64'd0);
    run(3'd0, 32'd3, 32'd3, 5'd18, 32'd9, "MUL 3x3 after rst");

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      logic [4:0]  rr;
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      rr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(ro, ra, rb, rr);
      wait_done(ref_op(ro, ra, rb), rr, "random", 0);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL have port start, input, 1 bit: request strobe, sampled at rising clk edges.
REQ-004 The block SHALL have port op, input, 3 bits: RV32M funct3 encoding.
- 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
- 4 DIV, 5 DIVU, 6 REM, 7 REMU
REQ-005 The block SHALL have port rs1_val, input, 32 bits: operand A, driven from register-file RD1.
REQ-006 The block SHALL have port rs2_val, input, 32 bits: operand B, driven from register-file RD2.
REQ-007 The block SHALL have port rd_in, input, 5 bits: destination register index for the request.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in flight.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port result, output, 32 bits: writeback data, feeding register-file WD.
REQ-011 The block SHALL have port rd_out, output, 5 bits: captured rd_in, feeding register-file A3.

Function
REQ-012 States SHALL be IDLE, RUN, FIX; one FSM plus a 6-bit iteration counter.
REQ-013 In IDLE, start=1 at edge T0 SHALL capture op, rs1_val, rs2_val and rd_in, set busy=1 and enter RUN.
REQ-014 Start while busy=1 SHALL be ignored; captured operands and op SHALL NOT change.
REQ-015 On entry to RUN, signed ops SHALL convert operands to magnitudes and record sign flags.
- MULH: both operands signed; MULHSU: rs1 signed, rs2 unsigned.
- DIV/REM: both signed.
REQ-016 RUN SHALL perform exactly 32 iterations, one per edge, on edges T1..T32.
- Multiply: shift-add into a 64-bit accumulator.
- Divide: restoring shift-subtract giving a 32-bit quotient and 32-bit remainder.
REQ-017 At edge T33 (FIX), the block SHALL apply sign correction, register result, set busy=0 and done=1, and return to IDLE.
REQ-018 Sign correction SHALL be: product negated if the sign flags differ; quotient negated if dividend and divisor signs differ; remainder takes the dividend's sign.
REQ-019 done SHALL be high for exactly one cycle (T33 to T34).
REQ-020 result and rd_out SHALL hold their values until the next completion or reset.
REQ-021 Result selection SHALL be: MUL low 32 bits of product; MULH/MULHSU/MULHU high 32 bits; DIV/DIVU quotient; REM/REMU remainder.
REQ-022 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = rs1_val, for signed and unsigned ops, with no exception signal.
REQ-023 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0.
REQ-024 Latency SHALL be fixed at 33 cycles from start acceptance to done for all ops, including the REQ-022 and REQ-023 special cases.
REQ-025 A new start SHALL be accepted in the cycle done is high, since busy=0 then (back-to-back operation).

Reset
REQ-026 rst=1 SHALL immediately force: state IDLE, busy=0, done=0, result=0, rd_out=0, counter=0, accumulators=0.
REQ-027 rst asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-028 After rst deasserts, the first start SHALL be accepted normally.

Verification
REQ-029 MUL 7 x 6, rd_in=5: done exactly 33 cycles after start -> result=42, rd_out=5.
REQ-030 MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-031 DIV -7 / 2 -> 0xFFFFFFFD (-3); REM -7 / 2 -> 0xFFFFFFFF (-1); DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-032 DIV 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0; each after 33 cycles.
REQ-033 start pulsed at cycle 10 of a run with different operands -> ignored, first result unchanged; start held in the done cycle -> second op completes 33 cycles later.
REQ-034 rst pulsed at cycle 15 of DIV -> busy=0 and result=0 immediately, no done pulse; a subsequent MUL 3 x 3 -> 9.
